// File: rtl/dmem_responder.sv
// Data-memory target: byte-masked word array with a ready/valid response path
// and a programmable number of wait states per accepted request.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  output logic        o_dmem_ready,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_rvalid,
  output logic        o_dmem_err
);

  localparam int         AW   = $clog2(DEPTH);
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pend_rd_q, pend_rd_d;
  logic        pend_err_q, pend_err_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          out_of_range;
  logic          illegal;
  logic          accept;
  logic          mem_we;
  logic [31:0]   rd_word;

  assign idx          = i_dmem_addr[AW+1:2];
  assign out_of_range = (i_dmem_addr >> (AW + 2)) != 32'd0;
  assign illegal      = (i_dmem_ren & i_dmem_wen) | out_of_range;
  assign accept       = (i_dmem_ren | i_dmem_wen) & (state_q == ST_IDLE);
  assign mem_we       = accept & i_dmem_wen & ~illegal;
  // Illegal reads return zero, so the hold value is forced here at acceptance.
  assign rd_word      = (i_dmem_ren & ~illegal) ? mem[idx] : 32'd0;

  // NOTE: the array has no reset so it can map onto RAM; contents survive i_rst_n.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (i_dmem_mask[k]) mem[idx][8*k +: 8] <= i_dmem_wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_rd_d   = pend_rd_q;
    pend_err_d  = pend_err_q;
    pend_data_d = pend_data_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    rdata_d     = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            rvalid_d = i_dmem_ren;
            err_d    = illegal;
            rdata_d  = rd_word;
          end else begin
            state_d     = ST_WAIT;
            cnt_d       = LAT4;
            pend_rd_d   = i_dmem_ren;
            pend_err_d  = illegal;
            pend_data_d = rd_word;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d  = ST_IDLE;
          rvalid_d = pend_rd_q;
          err_d    = pend_err_q;
          rdata_d  = pend_data_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      pend_rd_q   <= 1'b0;
      pend_err_q  <= 1'b0;
      pend_data_q <= 32'd0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_rd_q   <= pend_rd_d;
      pend_err_q  <= pend_err_d;
      pend_data_q <= pend_data_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign o_dmem_ready  = (state_q == ST_IDLE);
  assign o_dmem_rdata  = rdata_q;
  assign o_dmem_rvalid = rvalid_q;
  assign o_dmem_err    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 0, 3, 5) checked every
// cycle against an edge-scheduled reference model plus directed literal checks.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int NI    = 3;

  function automatic int lat_of(input int g);
    return (g == 0) ? 0 : (g == 1) ? 3 : 5;
  endfunction

  logic        clk;
  logic [2:0]  rst_n;
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [3:0]  mask  [NI];
  logic [2:0]  ren;
  logic [2:0]  wen;
  wire  [2:0]  ready;
  wire  [2:0]  rvalid;
  wire  [2:0]  err;
  wire  [31:0] rdata [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = lat_of(g);
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(L)) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n[g]),
      .i_dmem_addr  (addr[g]),
      .i_dmem_wdata (wdata[g]),
      .i_dmem_mask  (mask[g]),
      .i_dmem_ren   (ren[g]),
      .i_dmem_wen   (wen[g]),
      .o_dmem_ready (ready[g]),
      .o_dmem_rdata (rdata[g]),
      .o_dmem_rvalid(rvalid[g]),
      .o_dmem_err   (err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: responses scheduled by edge number.
  int          edge_n = 0;
  int          ready_from [NI];
  int          resp_edge  [NI];
  logic        exp_rv     [NI];
  logic        exp_err    [NI];
  logic [31:0] exp_data   [NI];
  logic [31:0] mem_m      [NI][DEPTH];

  initial begin
    for (int g = 0; g < NI; g++) begin
      ready_from[g] = 0;
      resp_edge[g]  = -1;
      exp_rv[g]     = 1'b0;
      exp_err[g]    = 1'b0;
      exp_data[g]   = 32'd0;
    end
  end

  always @(posedge clk) begin
    edge_n++;
    for (int g = 0; g < NI; g++) begin
      if (!rst_n[g]) begin
        ready_from[g] = 0;
        resp_edge[g]  = -1;
      end else if ((edge_n - 1 >= ready_from[g]) && (ren[g] || wen[g])) begin
        bit bad;
        int w;
        bad = (ren[g] && wen[g]) || (addr[g] >= 32'(DEPTH * 4));
        w   = bad ? 0 : int'(addr[g] / 4);
        exp_rv[g]   = ren[g];
        exp_err[g]  = bad;
        exp_data[g] = (ren[g] && !bad) ? mem_m[g][w] : 32'd0;
        if (wen[g] && !bad) begin
          for (int k = 0; k < 4; k++)
            if (mask[g][k]) mem_m[g][w][8*k +: 8] = wdata[g][8*k +: 8];
        end
        resp_edge[g]  = edge_n + lat_of(g);
        ready_from[g] = edge_n + lat_of(g);
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      logic        e_rdy, e_rv, e_err, hit;
      logic [31:0] e_d;
      if (!rst_n[g]) begin
        e_rdy = 1'b1; e_rv = 1'b0; e_err = 1'b0; e_d = 32'd0;
      end else begin
        hit   = (edge_n == resp_edge[g]);
        e_rdy = (edge_n >= ready_from[g]);
        e_rv  = hit && exp_rv[g];
        e_err = hit && exp_err[g];
        e_d   = hit ? exp_data[g] : 32'd0;
      end
      check($sformatf("ready[%0d]", g),  32'(ready[g]),  32'(e_rdy));
      check($sformatf("rvalid[%0d]", g), 32'(rvalid[g]), 32'(e_rv));
      check($sformatf("err[%0d]", g),    32'(err[g]),    32'(e_err));
      check($sformatf("rdata[%0d]", g),  rdata[g],       e_d);
    end
  end

  task automatic drive(input int g, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    ren[g]   = r;
    wen[g]   = w;
    addr[g]  = a;
    wdata[g] = d;
    mask[g]  = m;
  endtask

  task automatic idle(input int g);
    drive(g, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int g, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    drive(g, 1'b0, 1'b1, a, d, m);
    tick(1);
    idle(g);
  endtask

  task automatic rd(input int g, input logic [31:0] a);
    drive(g, 1'b1, 1'b0, a, 32'd0, 4'd0);
    tick(1);
    idle(g);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 3'b000;
    for (int g = 0; g < NI; g++) idle(g);
    tick(2);
    check("rst_ready",  32'(ready[0]),  32'd1);
    check("rst_rvalid", 32'(rvalid[0]), 32'd0);
    check("rst_err",    32'(err[0]),    32'd0);
    check("rst_rdata",  rdata[0],       32'd0);
    rst_n = 3'b111;
    tick(1);

    // LATENCY=0: write then read on the next edge
    wr(0, 32'h10, 32'hDEADBEEF, 4'hF);
    rd(0, 32'h10);
    check("l0_raw_rvalid", 32'(rvalid[0]), 32'd1);
    check("l0_raw_rdata",  rdata[0],       32'hDEADBEEF);
    check("l0_raw_ready",  32'(ready[0]),  32'd1);

    // byte mask
    wr(0, 32'h20, 32'h11223344, 4'hF);
    wr(0, 32'h20, 32'hAABBCCDD, 4'b0101);
    rd(0, 32'h20);
    check("mask_rdata", rdata[0], 32'h11BB33DD);

    // illegal: out of range read, and ren&wen together
    rd(0, 32'h0000_1000);
    check("oor_err",    32'(err[0]),    32'd1);
    check("oor_rvalid", 32'(rvalid[0]), 32'd1);
    check("oor_rdata",  rdata[0],       32'd0);
    wr(0, 32'h8, 32'h12345678, 4'hF);
    drive(0, 1'b1, 1'b1, 32'h8, 32'hFFFFFFFF, 4'hF);
    tick(1);
    idle(0);
    check("both_err",    32'(err[0]),    32'd1);
    check("both_rvalid", 32'(rvalid[0]), 32'd1);
    check("both_rdata",  rdata[0],       32'd0);
    rd(0, 32'h8);
    check("both_unchanged", rdata[0], 32'h12345678);
    check("err_not_sticky", 32'(err[0]), 32'd0);

    // back-to-back at wrap-around indices 0 and DEPTH-1
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, d;
      a = (i % 2 == 0) ? 32'h0 : 32'((DEPTH - 1) * 4);
      d = 32'hA500_0000 + 32'(i) * 32'h0101_0101;
      wr(0, a, d, 4'hF);
      rd(0, a);
      check($sformatf("b2b_%0d", i), rdata[0], d);
    end

    // LATENCY=3: wait states and a request held through the wait
    wr(1, 32'h40, 32'hCAFEF00D, 4'hF);
    tick(3);
    wr(1, 32'h44, 32'h0BADC0DE, 4'hF);
    tick(3);
    check("l3_ready_before", 32'(ready[1]), 32'd1);
    drive(1, 1'b1, 1'b0, 32'h40, 32'd0, 4'd0);
    tick(1);
    drive(1, 1'b1, 1'b0, 32'h44, 32'd0, 4'd0);
    check("l3_ready_t1", 32'(ready[1]), 32'd0);
    tick(2);
    check("l3_ready_t3",  32'(ready[1]),  32'd0);
    check("l3_rvalid_t3", 32'(rvalid[1]), 32'd0);
    tick(1);
    check("l3_rvalid_t4", 32'(rvalid[1]), 32'd1);
    check("l3_rdata_t4",  rdata[1],       32'hCAFEF00D);
    check("l3_ready_t4",  32'(ready[1]),  32'd1);
    tick(1);
    idle(1);
    check("l3_ready_t5",  32'(ready[1]),  32'd0);
    check("l3_rvalid_t5", 32'(rvalid[1]), 32'd0);
    tick(3);
    check("l3_second_rvalid", 32'(rvalid[1]), 32'd1);
    check("l3_second_rdata",  rdata[1],       32'h0BADC0DE);

    // LATENCY=5: reset in the middle of a wait
    wr(2, 32'h80, 32'h55AA55AA, 4'hF);
    tick(5);
    rd(2, 32'h80);
    tick(1);
    #2;
    rst_n[2] = 1'b0;
    #1;
    check("l5_rst_ready",  32'(ready[2]),  32'd1);
    check("l5_rst_rvalid", 32'(rvalid[2]), 32'd0);
    check("l5_rst_err",    32'(err[2]),    32'd0);
    tick(1);
    rst_n[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("l5_no_resp", 32'(rvalid[2]), 32'd0);
    end
    rd(2, 32'h80);
    tick(5);
    check("l5_kept_rvalid", 32'(rvalid[2]), 32'd1);
    check("l5_kept_rdata",  rdata[2],       32'h55AA55AA);

    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
